// File: rtl/cascade_counter_pkg.sv
// Shared counter definitions: operating modes and parameter legality check
// used by the counter family.
package cascade_counter_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'd0,
    MODE_INC  = 2'd1,
    MODE_DEC  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  // Pure binary digits, or 4-bit BCD digits.
  function automatic bit radix_legal(input int digit_w, input int radix);
    return (radix == (1 << digit_w)) || ((radix == 10) && (digit_w == 4));
  endfunction

endpackage

// File: rtl/cascade_counter_if.sv
// Control and status bundle of a cascade_counter; the master drives mode,
// load data and carry-in, the slave returns count, carry-out and wrap flags.
interface cascade_counter_if
  import cascade_counter_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 3
) ();

  localparam int N = DIGIT_W * DIGITS;

  mode_e          sel;
  logic [N-1:0]   d;
  logic           nCryIn;
  logic [N-1:0]   q;
  logic           nCryOut;
  logic           tc;
  logic           ovf;

  modport master (output sel, d, nCryIn, input  q, nCryOut, tc, ovf);
  modport slave  (input  sel, d, nCryIn, output q, nCryOut, tc, ovf);

endinterface

// File: rtl/cascade_counter_digit.sv
// One radix-RADIX counter digit. Steps only when enabled by the digits below
// it and reports whether it sits at the terminal value for the current mode.
module counter_digit
  import cascade_counter_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int RADIX   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  mode_e              mode,
  input  logic [DIGIT_W-1:0] load,
  input  logic               en,
  output logic [DIGIT_W-1:0] value,
  output logic               at_term
);

  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

  logic [DIGIT_W-1:0] next_value;

  // An out-of-range BCD digit counts as terminal when incrementing so it
  // rolls to 0 and carries, but decrements plainly without borrowing.
  always_comb begin
    at_term = 1'b0;
    case (mode)
      MODE_INC: at_term = (value >= MAX);
      MODE_DEC: at_term = (value == '0);
      default:  at_term = 1'b0;
    endcase
  end

  always_comb begin
    next_value = value;
    case (mode)
      MODE_LOAD: next_value = load;
      MODE_INC:
        if (en) next_value = (value >= MAX) ? '0 : value + DIGIT_W'(1);
      MODE_DEC:
        if (en) next_value = (value == '0) ? MAX : value - DIGIT_W'(1);
      default:   next_value = value;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= '0;
    else       value <= next_value;
  end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit loadable up/down counter with active-low carry chaining, so
// several instances can be stacked into one wider counter.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 3,
  parameter int RADIX   = 16
) (
  input logic               clk,
  input logic               reset,
  cascade_counter_if.slave  bus
);

  localparam int N = DIGIT_W * DIGITS;

  if (!radix_legal(DIGIT_W, RADIX)) begin : g_bad_radix
    $error("cascade_counter: RADIX %0d is not legal for DIGIT_W %0d", RADIX, DIGIT_W);
  end

  logic              count_op;
  logic [DIGITS:0]   en;
  logic [DIGITS-1:0] term;
  logic [N-1:0]      q_all;
  logic              all_term;
  logic              wrap;
  logic              n_cry;
  logic              tc_reg;
  logic              ovf_reg;

  assign count_op = (bus.sel == MODE_INC) || (bus.sel == MODE_DEC);
  assign en[0]    = count_op & ~bus.nCryIn;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    counter_digit #(
      .DIGIT_W (DIGIT_W),
      .RADIX   (RADIX)
    ) u_digit (
      .clk     (clk),
      .reset   (reset),
      .mode    (bus.sel),
      .load    (bus.d[k*DIGIT_W +: DIGIT_W]),
      .en      (en[k]),
      .value   (q_all[k*DIGIT_W +: DIGIT_W]),
      .at_term (term[k])
    );
    assign en[k+1] = en[k] & term[k];
  end

  // Enable reaching past the top digit means the whole counter wraps.
  assign wrap     = en[DIGITS];
  assign all_term = &term;

  // Carry-out ignores nCryIn so a stacked upper stage sees the lower
  // stage's terminal state directly.
  always_comb begin
    n_cry = 1'b1;
    case (bus.sel)
      MODE_LOAD: n_cry = 1'b0;
      MODE_INC,
      MODE_DEC:  n_cry = ~all_term;
      default:   n_cry = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      tc_reg <= wrap;
      if (bus.sel == MODE_LOAD) ovf_reg <= 1'b0;
      else if (wrap)            ovf_reg <= 1'b1;
    end
  end

  assign bus.q       = q_all;
  assign bus.nCryOut = n_cry;
  assign bus.tc      = tc_reg;
  assign bus.ovf     = ovf_reg;

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench: a hex counter, a BCD counter and two stacked hex counters
// run side by side against arithmetic reference models.
module tb_cascade_counter;
  import cascade_counter_pkg::*;

  typedef struct {
    logic [11:0] hex_q;
    logic        hex_nco;
    logic        hex_tc;
    logic        hex_ovf;
    logic [11:0] bcd_q;
    logic        bcd_nco;
    logic        bcd_tc;
    logic        bcd_ovf;
    logic [23:0] cas_q;
    logic        cas_nco;
    logic        cas_tc;
    logic        cas_ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  logic [11:0] m_hex;
  logic        m_hex_ovf;
  logic [11:0] m_bcd;
  logic        m_bcd_ovf;
  logic [23:0] m_cas;
  logic        m_cas_ovf;

  cascade_counter_if #(.DIGIT_W(4), .DIGITS(3)) hex_if ();
  cascade_counter_if #(.DIGIT_W(4), .DIGITS(3)) bcd_if ();
  cascade_counter_if #(.DIGIT_W(4), .DIGITS(3)) lo_if ();
  cascade_counter_if #(.DIGIT_W(4), .DIGITS(3)) hi_if ();

  cascade_counter #(.DIGIT_W(4), .DIGITS(3), .RADIX(16)) u_hex (
    .clk(clk), .reset(reset), .bus(hex_if));
  cascade_counter #(.DIGIT_W(4), .DIGITS(3), .RADIX(10)) u_bcd (
    .clk(clk), .reset(reset), .bus(bcd_if));
  cascade_counter #(.DIGIT_W(4), .DIGITS(3), .RADIX(16)) u_lo (
    .clk(clk), .reset(reset), .bus(lo_if));
  cascade_counter #(.DIGIT_W(4), .DIGITS(3), .RADIX(16)) u_hi (
    .clk(clk), .reset(reset), .bus(hi_if));

  // The stacked pair always counts; the upper stage follows the lower carry.
  assign lo_if.nCryIn = 1'b0;
  assign hi_if.nCryIn = lo_if.nCryOut;
  assign hi_if.sel    = lo_if.sel;

  always #5 clk = ~clk;

  function automatic logic nco_hex(input mode_e s, input logic [11:0] v);
    case (s)
      MODE_LOAD: return 1'b0;
      MODE_INC:  return v != 12'hFFF;
      MODE_DEC:  return v != 12'h000;
      default:   return 1'b1;
    endcase
  endfunction

  function automatic logic nco_bcd(input mode_e s, input logic [11:0] v);
    case (s)
      MODE_LOAD: return 1'b0;
      MODE_INC:  return !((v[3:0] >= 4'd9) && (v[7:4] >= 4'd9) && (v[11:8] >= 4'd9));
      MODE_DEC:  return v != 12'h000;
      default:   return 1'b1;
    endcase
  endfunction

  // Decimal add/subtract one, digit by digit, with carry or borrow.
  function automatic logic [11:0] bcd_step(input logic [11:0] v, input mode_e s,
                                           output logic wrap);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (c) begin
        if (s == MODE_INC) begin
          if (r[4*k +: 4] >= 4'd9) r[4*k +: 4] = 4'd0;
          else begin r[4*k +: 4] = r[4*k +: 4] + 4'd1; c = 1'b0; end
        end else begin
          if (r[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'd9;
          else begin r[4*k +: 4] = r[4*k +: 4] - 4'd1; c = 1'b0; end
        end
      end
    end
    wrap = c;
    return r;
  endfunction

  task automatic cmp(input string tag, input string name,
                     input logic [23:0] act, input logic [23:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("[TB] FAIL %s %s: got %h, expected %h", tag, name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e, input string tag);
    cmp(tag, "hex.q",   24'(hex_if.q),       24'(e.hex_q));
    cmp(tag, "hex.nco", 24'(hex_if.nCryOut), 24'(e.hex_nco));
    cmp(tag, "hex.tc",  24'(hex_if.tc),      24'(e.hex_tc));
    cmp(tag, "hex.ovf", 24'(hex_if.ovf),     24'(e.hex_ovf));
    cmp(tag, "bcd.q",   24'(bcd_if.q),       24'(e.bcd_q));
    cmp(tag, "bcd.nco", 24'(bcd_if.nCryOut), 24'(e.bcd_nco));
    cmp(tag, "bcd.tc",  24'(bcd_if.tc),      24'(e.bcd_tc));
    cmp(tag, "bcd.ovf", 24'(bcd_if.ovf),     24'(e.bcd_ovf));
    cmp(tag, "cas.q",   {hi_if.q, lo_if.q},  e.cas_q);
    cmp(tag, "cas.nco", 24'(hi_if.nCryOut),  24'(e.cas_nco));
    cmp(tag, "cas.tc",  24'(hi_if.tc),       24'(e.cas_tc));
    cmp(tag, "cas.ovf", 24'(hi_if.ovf),      24'(e.cas_ovf));
  endtask

  // Drive one cycle of stimulus and queue the response the models predict.
  task automatic applyStimulus(input mode_e s, input logic [11:0] hd,
                               input logic [11:0] bd, input logic [23:0] cd,
                               input logic n);
    exp_t e;
    logic w;
    @(negedge clk);
    hex_if.sel = s; hex_if.d = hd; hex_if.nCryIn = n;
    bcd_if.sel = s; bcd_if.d = bd; bcd_if.nCryIn = n;
    lo_if.sel  = s; lo_if.d  = cd[11:0]; hi_if.d = cd[23:12];

    w = 1'b0;
    if (s == MODE_LOAD) begin
      m_hex = hd; m_hex_ovf = 1'b0;
    end else if (s == MODE_INC && !n) begin
      w = (m_hex == 12'hFFF); m_hex = m_hex + 12'd1;
    end else if (s == MODE_DEC && !n) begin
      w = (m_hex == 12'h000); m_hex = m_hex - 12'd1;
    end
    if (w) m_hex_ovf = 1'b1;
    e.hex_q = m_hex; e.hex_tc = w; e.hex_ovf = m_hex_ovf; e.hex_nco = nco_hex(s, m_hex);

    w = 1'b0;
    if (s == MODE_LOAD) begin
      m_bcd = bd; m_bcd_ovf = 1'b0;
    end else if ((s == MODE_INC || s == MODE_DEC) && !n) begin
      m_bcd = bcd_step(m_bcd, s, w);
    end
    if (w) m_bcd_ovf = 1'b1;
    e.bcd_q = m_bcd; e.bcd_tc = w; e.bcd_ovf = m_bcd_ovf; e.bcd_nco = nco_bcd(s, m_bcd);

    w = 1'b0;
    if (s == MODE_LOAD) begin
      m_cas = cd; m_cas_ovf = 1'b0;
    end else if (s == MODE_INC) begin
      w = (m_cas == 24'hFFFFFF); m_cas = m_cas + 24'd1;
    end else if (s == MODE_DEC) begin
      w = (m_cas == 24'h000000); m_cas = m_cas - 24'd1;
    end
    if (w) m_cas_ovf = 1'b1;
    e.cas_q = m_cas; e.cas_tc = w; e.cas_ovf = m_cas_ovf;
    e.cas_nco = nco_hex(s, m_cas[23:12]);

    exp_q.push_back(e);
  endtask

  function automatic exp_t reset_expect(input mode_e s);
    exp_t e;
    e.hex_q = '0; e.hex_tc = 1'b0; e.hex_ovf = 1'b0; e.hex_nco = nco_hex(s, 12'h000);
    e.bcd_q = '0; e.bcd_tc = 1'b0; e.bcd_ovf = 1'b0; e.bcd_nco = nco_bcd(s, 12'h000);
    e.cas_q = '0; e.cas_tc = 1'b0; e.cas_ovf = 1'b0; e.cas_nco = nco_hex(s, 12'h000);
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front(), "cycle");
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mode_e       rs;
    logic [11:0] rh;
    logic [11:0] rb;
    logic [23:0] rc;

    reset = 1'b1;
    hex_if.sel = MODE_HOLD; hex_if.d = '0; hex_if.nCryIn = 1'b1;
    bcd_if.sel = MODE_HOLD; bcd_if.d = '0; bcd_if.nCryIn = 1'b1;
    lo_if.sel  = MODE_HOLD; lo_if.d  = '0; hi_if.d = '0;
    m_hex = '0; m_hex_ovf = 1'b0;
    m_bcd = '0; m_bcd_ovf = 1'b0;
    m_cas = '0; m_cas_ovf = 1'b0;
    #12;
    checkOutput(reset_expect(MODE_HOLD), "reset");
    #5 reset = 1'b0;

    // Wrap to zero, decimal carry and 24-bit carry across the stacked pair.
    applyStimulus(MODE_LOAD, 12'hFFE, 12'h099, 24'h000FFF, 1'b0);
    applyStimulus(MODE_INC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_INC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_INC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_LOAD, 12'h123, 12'h000, 24'h001000, 1'b0);
    applyStimulus(MODE_DEC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_LOAD, 12'h123, 12'h00C, 24'hFFFFFF, 1'b0);
    applyStimulus(MODE_INC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_LOAD, 12'h123, 12'h00C, 24'h000000, 1'b0);
    applyStimulus(MODE_DEC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_LOAD, 12'h123, 12'h123, 24'h123456, 1'b0);
    for (int i = 0; i < 5; i++)
      applyStimulus(MODE_INC, 12'h000, 12'h000, 24'h000000, 1'b1);
    applyStimulus(MODE_HOLD, 12'h000, 12'h000, 24'h000000, 1'b0);

    // Count up to 0x5A5 with both other counters wrapping, then reset mid-cycle.
    applyStimulus(MODE_LOAD, 12'h5A3, 12'h999, 24'hFFFFFF, 1'b0);
    applyStimulus(MODE_INC,  12'h000, 12'h000, 24'h000000, 1'b0);
    applyStimulus(MODE_INC,  12'h000, 12'h000, 24'h000000, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 checkOutput(reset_expect(MODE_INC), "async_reset");
    m_hex = '0; m_hex_ovf = 1'b0;
    m_bcd = '0; m_bcd_ovf = 1'b0;
    m_cas = '0; m_cas_ovf = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus(MODE_INC, 12'h000, 12'h000, 24'h000000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rs = mode_e'(2'($urandom_range(0, 3)));
      rh = ($urandom_range(0, 5) == 0) ? 12'hFFF : 12'($urandom);
      for (int k = 0; k < 3; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
      rc = ($urandom_range(0, 5) == 0) ? 24'hFFFFFE : 24'($urandom);
      applyStimulus(rs, rh, rb, rc, ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
